icache_loader: RTL and testbench

Boot-time instruction loader for the single-cycle RISC-V core. It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit words, and writes them into the instruction cache write port at consecutive word addresses. It holds the core in reset for the whole load and validates the image with an XOR checksum. It is the writer side of the instruction cache, which the core only ever reads through `pc_r[7:2]`.

---
 rtl/icache_loader.sv | 187 ++++++++++++++++++
 tb/tb_icache_loader.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_loader.sv
`default_nettype none
// ============================================================================
// Module   : icache_loader
// Purpose  : Boot-time instruction loader. Receives a byte stream
//            (count, little-endian words, XOR checksum) over valid/ready,
//            writes assembled words into the instruction cache write port
//            and holds the core in reset until the image is validated.
// Revision : 1.0  initial release
// ============================================================================
module icache_loader #(
   parameter int DEPTH_W = 64,
   parameter int ADDR_W  = 6
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic              byte_valid_i,
   input  logic [7:0]        byte_i,
   output logic              byte_ready_o,
   output logic              wr_en_o,
   output logic [ADDR_W-1:0] wr_addr_o,
   output logic [31:0]       wr_data_o,
   output logic              core_rst_no,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o
);

   // Word counter is one bit wider than the index so it can hold DEPTH_W.
   localparam int                CNT_W   = ADDR_W + 1;
   localparam logic [8:0]        C_DEPTH = 9'(DEPTH_W);
   localparam logic [CNT_W-1:0]  C_FULL  = CNT_W'(DEPTH_W);
   localparam logic [CNT_W-1:0]  C_ONE   = CNT_W'(1);

   localparam logic [2:0] C_ST_IDLE  = 3'd0;
   localparam logic [2:0] C_ST_COUNT = 3'd1;
   localparam logic [2:0] C_ST_DATA  = 3'd2;
   localparam logic [2:0] C_ST_CHECK = 3'd3;
   localparam logic [2:0] C_ST_DONE  = 3'd4;
   localparam logic [2:0] C_ST_ERROR = 3'd5;

   logic [2:0]        state_q,   state_d;
   logic [7:0]        xor_q,     xor_d;
   logic [1:0]        lane_q,    lane_d;
   logic [ADDR_W-1:0] idx_q,     idx_d;
   logic [CNT_W-1:0]  cnt_q,     cnt_d;
   logic [23:0]       asm_q,     asm_d;
   logic              wr_en_q,   wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [31:0]       wr_data_q, wr_data_d;

   logic w_loading;
   logic w_xfer;
   logic w_restart;
   logic w_oversize;
   logic w_last_byte;

   // Handshake and decode terms shared by the next-state and datapath logic.
   always_comb begin
      w_loading   = (state_q == C_ST_COUNT) || (state_q == C_ST_DATA) ||
                    (state_q == C_ST_CHECK);
      w_xfer      = w_loading && byte_valid_i;
      w_restart   = start_i && ((state_q == C_ST_IDLE) || (state_q == C_ST_ERROR));
      w_oversize  = {1'b0, byte_i} > C_DEPTH;
      w_last_byte = (lane_q == 2'd3);
   end

   // State register.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= C_ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         C_ST_IDLE: begin
            if (start_i) state_d = C_ST_COUNT;
         end
         C_ST_COUNT: begin
            if (w_xfer) state_d = w_oversize ? C_ST_ERROR : C_ST_DATA;
         end
         C_ST_DATA: begin
            // The last byte of the last word leaves DATA.
            if (w_xfer && w_last_byte && (cnt_q == C_ONE)) state_d = C_ST_CHECK;
         end
         C_ST_CHECK: begin
            if (w_xfer) state_d = (byte_i == xor_q) ? C_ST_DONE : C_ST_ERROR;
         end
         C_ST_DONE: begin
            state_d = C_ST_IDLE;
         end
         C_ST_ERROR: begin
            if (start_i) state_d = C_ST_COUNT;
         end
         default: begin
            state_d = C_ST_IDLE;
         end
      endcase
   end

   // Status outputs are decoded from state alone, so none of them depend
   // combinationally on the stream inputs.
   always_comb begin
      byte_ready_o = w_loading;
      busy_o       = w_loading;
      done_o       = (state_q == C_ST_DONE);
      err_o        = (state_q == C_ST_ERROR);
      core_rst_no  = (state_q == C_ST_IDLE) || (state_q == C_ST_DONE);
   end

   // Datapath: checksum accumulation, word assembly and write registration.
   always_comb begin
      xor_d     = xor_q;
      lane_d    = lane_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      asm_d     = asm_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;

      if (w_restart) begin
         xor_d  = 8'h00;
         lane_d = 2'd0;
         idx_d  = '0;
      end

      if (w_xfer && (state_q == C_ST_COUNT)) begin
         xor_d = byte_i;
         // A count byte of zero encodes a full cache image.
         cnt_d = (byte_i == 8'h00) ? C_FULL : CNT_W'(byte_i);
      end

      if (w_xfer && (state_q == C_ST_DATA)) begin
         xor_d = xor_q ^ byte_i;
         if (w_last_byte) begin
            // Lanes 0..2 are already held; lane 3 completes the word.
            wr_en_d   = 1'b1;
            wr_addr_d = idx_q;
            wr_data_d = {byte_i, asm_q};
            idx_d     = idx_q + ADDR_W'(1);
            cnt_d     = cnt_q - C_ONE;
            lane_d    = 2'd0;
         end else begin
            asm_d[{lane_q, 3'b000} +: 8] = byte_i;
            lane_d                       = lane_q + 2'd1;
         end
      end
   end

   // Datapath registers; a reset discards any partially assembled word.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         xor_q     <= 8'h00;
         lane_q    <= 2'd0;
         idx_q     <= '0;
         cnt_q     <= '0;
         asm_q     <= 24'h000000;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= 32'h0000_0000;
      end else begin
         xor_q     <= xor_d;
         lane_q    <= lane_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         asm_q     <= asm_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   end

   // Registered write port drives the cache directly.
   always_comb begin
      wr_en_o   = wr_en_q;
      wr_addr_o = wr_addr_q;
      wr_data_o = wr_data_q;
   end

endmodule
`default_nettype wire

// File: tb/tb_icache_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_icache_loader
// Purpose  : Self-checking bench for icache_loader. A stream-position model
//            predicts every output each cycle; directed tests add literal
//            expectations on the words written and the status pulses.
// Revision : 1.0  initial release
// ============================================================================
module tb_icache_loader;

   localparam int ADDR_W = 6;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic              bv;
   logic [7:0]        bt;
   logic              byte_ready;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [31:0]       wr_data;
   logic              core_rst_n;
   logic              busy;
   logic              done;
   logic              err;

   always #5 clk = ~clk;

   icache_loader #(.DEPTH_W(64), .ADDR_W(ADDR_W)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .start_i     (start),
      .byte_valid_i(bv),
      .byte_i      (bt),
      .byte_ready_o(byte_ready),
      .wr_en_o     (wr_en),
      .wr_addr_o   (wr_addr),
      .wr_data_o   (wr_data),
      .core_rst_no (core_rst_n),
      .busy_o      (busy),
      .done_o      (done),
      .err_o       (err)
   );

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   // Phases: 0 idle, 1 loading, 2 done, 3 error. pos counts stream bytes
   // consumed since start (0 = count byte, 1..4n = data, 4n+1 = checksum).
   int          ph = 0;
   int          pos = 0;
   int          n = 0;
   int          k;
   logic [7:0]  x = 8'h00;
   logic [31:0] w = 32'h0;
   bit          exp_wr_en = 1'b0;
   int          exp_addr = 0;
   logic [31:0] exp_data = 32'h0;
   bit          mdl_ok = 1'b0;

   // Model update at each rising edge from the bench's own input drive.
   always @(posedge clk) begin
      if (!rst_n) begin
         ph = 0; exp_wr_en = 1'b0; exp_addr = 0; exp_data = 32'h0; mdl_ok = 1'b1;
      end else if (mdl_ok) begin
         exp_wr_en = 1'b0;
         case (ph)
            0, 3: if (start) begin ph = 1; pos = 0; w = 32'h0; end
            2: ph = 0;
            1: if (bv) begin
               if (pos == 0) begin
                  n = (bt == 8'h00) ? 64 : int'(bt);
                  x = bt;
                  if (int'(bt) > 64) ph = 3; else pos = 1;
               end else if (pos <= 4 * n) begin
                  k = (pos - 1) % 4;
                  w = w | (32'(bt) << (8 * k));
                  x = x ^ bt;
                  if (k == 3) begin
                     exp_wr_en = 1'b1;
                     exp_addr  = (pos - 1) / 4;
                     exp_data  = w;
                     w = 32'h0;
                  end
                  pos++;
               end else begin
                  ph = (bt == x) ? 2 : 3;
               end
            end
            default: ph = 0;
         endcase
      end
   end

   // Observed write image and pulse counters.
   logic [31:0] mem [64];
   int          wr_count   = 0;
   int          done_count = 0;

   // Compare process: every cycle once the model has seen reset.
   always @(negedge clk) begin
      if (mdl_ok) begin
         chk("byte_ready", 32'(byte_ready), 32'(ph == 1));
         chk("busy",       32'(busy),       32'(ph == 1));
         chk("core_rst_n", 32'(core_rst_n), 32'(ph == 0 || ph == 2));
         chk("done",       32'(done),       32'(ph == 2));
         chk("err",        32'(err),        32'(ph == 3));
         chk("wr_en",      32'(wr_en),      32'(exp_wr_en));
         chk("wr_addr",    32'(wr_addr),    32'(exp_addr));
         chk("wr_data",    wr_data,         exp_data);
         if (wr_en === 1'b1) begin
            mem[wr_addr] = wr_data;
            wr_count++;
         end
         if (done === 1'b1) done_count++;
      end
   end

   // ---------------- stimulus ----------------
   logic [7:0] stream [$];

   task automatic idle(input int cycles);
      repeat (cycles) @(negedge clk);
   endtask

   task automatic do_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   // Send the stream; optional one-cycle gaps and stray start pulses.
   task automatic send(input bit stall, input bit pulse_start);
      for (int i = 0; i < stream.size(); i++) begin
         @(negedge clk);
         bv = 1'b1; bt = stream[i];
         start = pulse_start && (i % 3 == 1);
         if (stall) begin
            @(negedge clk);
            bv = 1'b0; start = 1'b0;
         end
      end
      @(negedge clk);
      bv = 1'b0; start = 1'b0;
   endtask

   task automatic clear_obs();
      wr_count = 0; done_count = 0;
      for (int i = 0; i < 64; i++) mem[i] = 32'hDEAD_BEEF;
   endtask

   task automatic two_word_stream();
      stream = {8'h02, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00, 8'hC3};
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; bv = 1'b0; bt = 8'h00;
      clear_obs();
      idle(2);
      chk("reset core_rst_n", 32'(core_rst_n), 32'd1);
      chk("reset byte_ready", 32'(byte_ready), 32'd0);
      chk("reset wr_en",      32'(wr_en),      32'd0);
      chk("reset wr_data",    wr_data,         32'd0);
      rst_n = 1'b1;
      idle(2);

      // Single word
      clear_obs();
      do_start();
      chk("start core_rst_n", 32'(core_rst_n), 32'd0);
      chk("start byte_ready", 32'(byte_ready), 32'd1);
      stream = {8'h01, 8'h13, 8'h00, 8'h00, 8'h00, 8'h12};
      send(1'b0, 1'b0);
      idle(3);
      chk("single writes", 32'(wr_count), 32'd1);
      chk("single word0",  mem[0], 32'h0000_0013);
      chk("single done",   32'(done_count), 32'd1);
      chk("single core_rst_n", 32'(core_rst_n), 32'd1);

      // Bad checksum
      clear_obs();
      do_start();
      stream = {8'h01, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
      send(1'b0, 1'b0);
      idle(5);
      chk("badsum writes", 32'(wr_count), 32'd1);
      chk("badsum done",   32'(done_count), 32'd0);
      chk("badsum err",    32'(err), 32'd1);
      chk("badsum core_rst_n", 32'(core_rst_n), 32'd0);

      // Oversize count, then recovery
      clear_obs();
      do_start();
      stream = {8'h41};
      send(1'b0, 1'b0);
      idle(3);
      chk("oversize err",   32'(err), 32'd1);
      chk("oversize ready", 32'(byte_ready), 32'd0);
      chk("oversize writes", 32'(wr_count), 32'd0);
      do_start();
      chk("restart err", 32'(err), 32'd0);
      stream = {8'h01, 8'h13, 8'h00, 8'h00, 8'h00, 8'h12};
      send(1'b0, 1'b0);
      idle(3);
      chk("recover done", 32'(done_count), 32'd1);
      chk("recover word0", mem[0], 32'h0000_0013);

      // Full image
      clear_obs();
      do_start();
      stream = {8'h00};
      for (int i = 0; i < 64; i++) begin
         stream.push_back(8'(i)); stream.push_back(8'h00);
         stream.push_back(8'h00); stream.push_back(8'h00);
      end
      stream.push_back(8'h00);
      send(1'b0, 1'b0);
      idle(3);
      chk("full writes", 32'(wr_count), 32'd64);
      chk("full done",   32'(done_count), 32'd1);
      for (int i = 0; i < 64; i++) chk("full word", mem[i], 32'(i));

      // Stalls with stray start pulses
      clear_obs();
      do_start();
      two_word_stream();
      send(1'b1, 1'b1);
      idle(3);
      chk("stall writes", 32'(wr_count), 32'd2);
      chk("stall word0",  mem[0], 32'h0050_0093);
      chk("stall word1",  mem[1], 32'h0010_0113);
      chk("stall done",   32'(done_count), 32'd1);

      // Reset mid-load after byte 3 of word 1
      clear_obs();
      do_start();
      two_word_stream();
      stream = stream[0:7];
      for (int i = 0; i < stream.size(); i++) begin
         @(negedge clk); bv = 1'b1; bt = stream[i];
      end
      @(negedge clk); bv = 1'b0; rst_n = 1'b0;
      @(negedge clk);
      chk("midrst wr_en",      32'(wr_en), 32'd0);
      chk("midrst core_rst_n", 32'(core_rst_n), 32'd1);
      chk("midrst busy",       32'(busy), 32'd0);
      chk("midrst wr_addr",    32'(wr_addr), 32'd0);
      rst_n = 1'b1;
      idle(2);
      chk("midrst writes", 32'(wr_count), 32'd1);
      clear_obs();
      do_start();
      two_word_stream();
      send(1'b0, 1'b0);
      idle(3);
      chk("after rst word1", mem[1], 32'h0010_0113);
      chk("after rst done",  32'(done_count), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
